// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush generation, EX forwarding selects,
// data-memory freeze tracking and saturating hazard event counters.
module hazard_unit #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [1:0]       resultSrcE,
  input  logic             pcSrcE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memReqM,
  input  logic             dmemReadyM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic             memTimeout
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             timeout_q;
  logic             freeze, lw_stall, timeout_hit;

  assign freeze   = memReqM & ~dmemReadyM;
  assign lw_stall = (resultSrcE == 2'b01) && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        wait_cnt_d = '0;
        if (freeze) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (wait_cnt_q != WC_W'(TIMEOUT)) wait_cnt_d = wait_cnt_q + WC_W'(1);
        if (dmemReadyM) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Visible in the same cycle the wait budget runs out; the sticky flag holds it afterwards.
  assign timeout_hit = (state_q == MEM_WAIT) && !dmemReadyM &&
                       (wait_cnt_q == WC_W'(TIMEOUT));

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (!rst) begin
      if (freeze) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end else if (pcSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lw_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end

      if (regWriteM && rdM != 5'd0 && rdM == rs1E)      forwardAE = 2'b10;
      else if (regWriteW && rdW != 5'd0 && rdW == rs1E) forwardAE = 2'b01;

      if (regWriteM && rdM != 5'd0 && rdM == rs2E)      forwardBE = 2'b10;
      else if (regWriteW && rdW != 5'd0 && rdW == rs2E) forwardBE = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (timeout_hit) timeout_q <= 1'b1;
      if (stallF && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flushE && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stallCnt   = stall_cnt_q;
  assign flushCnt   = flush_cnt_q;
  assign memTimeout = timeout_q | timeout_hit;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expected output vectors are queued as
// stimulus is applied and compared at the following negative clock edge.
module tb_hazard_unit;

  localparam int CNT_W = 4;
  localparam int TMO   = 4;

  // {memTimeout, stallF, stallD, stallE, stallM, flushD, flushE, fwdA[1:0], fwdB[1:0]}
  localparam bit [10:0] NONE  = 11'h000;
  localparam bit [10:0] FRZ   = 11'h3C0;
  localparam bit [10:0] FLUSH = 11'h030;
  localparam bit [10:0] LW    = 11'h310;
  localparam bit [10:0] FA_M  = 11'h008;
  localparam bit [10:0] FA_W  = 11'h004;
  localparam bit [10:0] FB_M  = 11'h002;
  localparam bit [10:0] FB_W  = 11'h001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] resultSrcE;
  logic pcSrcE, regWriteM, regWriteW, memReqM, dmemReadyM;
  logic stallF, stallD, stallE, stallM, flushD, flushE;
  logic [1:0] forwardAE, forwardBE;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic memTimeout;

  bit [10:0] sb[$];
  bit [10:0] e, row;
  logic [CNT_W-1:0] exp_sc, exp_fc;
  bit exp_to;
  int n_chk, n_fail;

  hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .resultSrcE(resultSrcE), .pcSrcE(pcSrcE), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memReqM(memReqM), .dmemReadyM(dmemReadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallCnt(stallCnt), .flushCnt(flushCnt), .memTimeout(memTimeout)
  );

  always #5 clk = ~clk;

  function automatic bit [10:0] outv();
    return {memTimeout, stallF, stallD, stallE, stallM, flushD, flushE, forwardAE, forwardBE};
  endfunction

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    resultSrcE = 2'b00; pcSrcE = 0; regWriteM = 0; regWriteW = 0;
    memReqM = 0; dmemReadyM = 0;
  endtask

  // Reference counter model: each cycle's expected stallF/flushE lands on the next edge.
  task automatic upd(input bit [10:0] x);
    if (x[9] && exp_sc != '1) exp_sc = exp_sc + 1'b1;
    if (x[4] && exp_fc != '1) exp_fc = exp_fc + 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      idle();
      rst = (i < 3);
      if (i < 3) begin
        pcSrcE = 1; resultSrcE = 2'b01; rdE = 5; rs1D = 5;
        regWriteM = 1; rdM = 3; rs1E = 3; memReqM = 1;
      end
      sb.push_back(NONE);
      @(negedge clk);
      e = sb.pop_front();
      n_chk += 3;
      if (stallCnt !== exp_sc) begin n_fail++; $display("FAIL reset stallCnt row %0d: got %0d want %0d", i, stallCnt, exp_sc); end
      if (flushCnt !== exp_fc) begin n_fail++; $display("FAIL reset flushCnt row %0d: got %0d want %0d", i, flushCnt, exp_fc); end
      if (outv() !== e) begin n_fail++; $display("FAIL reset outputs row %0d: got %b want %b", i, outv(), e); end
      upd(e);
    end
  endtask

  task automatic test_lw_stall();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      idle();
      case (i)
        0: begin resultSrcE = 2'b01; rdE = 5; rs1D = 5; row = LW; end
        2: begin resultSrcE = 2'b01; rdE = 7; rs2D = 7; row = LW; end
        3: begin resultSrcE = 2'b01; rdE = 0; rs1D = 0; row = NONE; end
        4: begin resultSrcE = 2'b10; rdE = 5; rs1D = 5; row = NONE; end
        5: begin resultSrcE = 2'b01; rdE = 6; rs1D = 5; rs2D = 4; row = NONE; end
        default: row = NONE;
      endcase
      sb.push_back({exp_to, row[9:0]});
      @(negedge clk);
      e = sb.pop_front();
      n_chk += 3;
      if (stallCnt !== exp_sc) begin n_fail++; $display("FAIL lw stallCnt row %0d: got %0d want %0d", i, stallCnt, exp_sc); end
      if (flushCnt !== exp_fc) begin n_fail++; $display("FAIL lw flushCnt row %0d: got %0d want %0d", i, flushCnt, exp_fc); end
      if (outv() !== e) begin n_fail++; $display("FAIL lw outputs row %0d: got %b want %b", i, outv(), e); end
      upd(e);
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      idle();
      case (i)
        0: begin regWriteM = 1; rdM = 3; regWriteW = 1; rdW = 3; rs1E = 3; row = FA_M; end
        1: begin regWriteM = 1; rdM = 0; regWriteW = 1; rdW = 3; rs1E = 3; row = FA_W; end
        2: begin regWriteM = 1; rdM = 0; regWriteW = 1; rdW = 0; rs1E = 0; rs2E = 0; row = NONE; end
        3: begin regWriteM = 0; rdM = 7; regWriteW = 1; rdW = 7; rs2E = 7; row = FB_W; end
        4: begin regWriteM = 1; rdM = 9; regWriteW = 1; rdW = 9; rs2E = 9; rs1E = 9; row = FA_M | FB_M; end
        5: begin regWriteM = 0; rdM = 4; regWriteW = 0; rdW = 4; rs1E = 4; rs2E = 4; row = NONE; end
        default: begin regWriteM = 1; rdM = 12; regWriteW = 1; rdW = 13; rs1E = 13; rs2E = 12; row = FA_W | FB_M; end
      endcase
      sb.push_back({exp_to, row[9:0]});
      @(negedge clk);
      e = sb.pop_front();
      n_chk += 1;
      if (outv() !== e) begin n_fail++; $display("FAIL fwd outputs row %0d: got %b want %b", i, outv(), e); end
      upd(e);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      idle();
      case (i)
        0: begin pcSrcE = 1; resultSrcE = 2'b01; rdE = 5; rs1D = 5; row = FLUSH; end
        1: begin pcSrcE = 1; row = FLUSH; end
        default: row = NONE;
      endcase
      sb.push_back({exp_to, row[9:0]});
      @(negedge clk);
      e = sb.pop_front();
      n_chk += 3;
      if (stallCnt !== exp_sc) begin n_fail++; $display("FAIL branch stallCnt row %0d: got %0d want %0d", i, stallCnt, exp_sc); end
      if (flushCnt !== exp_fc) begin n_fail++; $display("FAIL branch flushCnt row %0d: got %0d want %0d", i, flushCnt, exp_fc); end
      if (outv() !== e) begin n_fail++; $display("FAIL branch outputs row %0d: got %b want %b", i, outv(), e); end
      upd(e);
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      idle();
      if (i < 5) begin
        memReqM = 1; dmemReadyM = (i == 4); pcSrcE = 1;
        resultSrcE = 2'b01; rdE = 5; rs1D = 5;
        regWriteM = 1; rdM = 3; rs1E = 3;
      end
      row = (i < 4) ? (FRZ | FA_M) : (i == 4) ? (FLUSH | FA_M) : NONE;
      sb.push_back({exp_to, row[9:0]});
      @(negedge clk);
      e = sb.pop_front();
      n_chk += 3;
      if (stallCnt !== exp_sc) begin n_fail++; $display("FAIL memwait stallCnt row %0d: got %0d want %0d", i, stallCnt, exp_sc); end
      if (flushCnt !== exp_fc) begin n_fail++; $display("FAIL memwait flushCnt row %0d: got %0d want %0d", i, flushCnt, exp_fc); end
      if (outv() !== e) begin n_fail++; $display("FAIL memwait outputs row %0d: got %b want %b", i, outv(), e); end
      upd(e);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      idle();
      if (i < 7) begin memReqM = 1; dmemReadyM = (i == 6); end
      // Wait cycles in MEM_WAIT are rows 1..5; the budget of TMO is exhausted on row 5.
      if (i == 5) exp_to = 1;
      row = (i < 6) ? FRZ : NONE;
      sb.push_back({exp_to, row[9:0]});
      @(negedge clk);
      e = sb.pop_front();
      n_chk += 2;
      if (stallCnt !== exp_sc) begin n_fail++; $display("FAIL timeout stallCnt row %0d: got %0d want %0d", i, stallCnt, exp_sc); end
      if (outv() !== e) begin n_fail++; $display("FAIL timeout outputs row %0d: got %b want %b", i, outv(), e); end
      upd(e);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      idle();
      case (i)
        0, 1: begin memReqM = 1; pcSrcE = 1; row = FRZ; end
        2: begin
          rst = 1; memReqM = 1; pcSrcE = 1; regWriteM = 1; rdM = 3; rs1E = 3;
          exp_sc = '0; exp_fc = '0; exp_to = 0; row = NONE;
        end
        3: begin rst = 0; pcSrcE = 1; row = FLUSH; end
        default: row = NONE;
      endcase
      sb.push_back({exp_to, row[9:0]});
      @(negedge clk);
      e = sb.pop_front();
      n_chk += 3;
      if (stallCnt !== exp_sc) begin n_fail++; $display("FAIL rstwait stallCnt row %0d: got %0d want %0d", i, stallCnt, exp_sc); end
      if (flushCnt !== exp_fc) begin n_fail++; $display("FAIL rstwait flushCnt row %0d: got %0d want %0d", i, flushCnt, exp_fc); end
      if (outv() !== e) begin n_fail++; $display("FAIL rstwait outputs row %0d: got %b want %b", i, outv(), e); end
      upd(e);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      idle();
      if (i < 18) begin resultSrcE = 2'b01; rdE = 5'(i % 31 + 1); rs1D = 5'(i % 31 + 1); end
      row = (i < 18) ? LW : NONE;
      sb.push_back({exp_to, row[9:0]});
      @(negedge clk);
      e = sb.pop_front();
      n_chk += 3;
      if (stallCnt !== exp_sc) begin n_fail++; $display("FAIL b2b stallCnt row %0d: got %0d want %0d", i, stallCnt, exp_sc); end
      if (flushCnt !== exp_fc) begin n_fail++; $display("FAIL b2b flushCnt row %0d: got %0d want %0d", i, flushCnt, exp_fc); end
      if (outv() !== e) begin n_fail++; $display("FAIL b2b outputs row %0d: got %b want %b", i, outv(), e); end
      upd(e);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    exp_sc = '0; exp_fc = '0; exp_to = 0;
    rst = 1;
    idle();
    test_reset();
    test_lw_stall();
    test_forward();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
